// File: rtl/sobel_window_scheduler_if.sv
// sobel_window_scheduler_if: pixel-memory fetch and 3x3 window handshake bundle.
interface sobel_window_scheduler_if #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8
);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    logic                    start;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic [DATA_WIDTH-1:0]   pixel;
    logic                    win_valid;
    logic                    win_ready;
    logic [9*DATA_WIDTH-1:0] win_data;
    logic [RW-1:0]           win_row;
    logic [CW-1:0]           win_col;
    logic                    busy;
    logic                    done;
    modport master (
        input  start, pixel, win_ready,
        output row, col, win_valid, win_data, win_row, win_col, busy, done
    );
    modport slave (
        output start, pixel, win_ready,
        input  row, col, win_valid, win_data, win_row, win_col, busy, done
    );
endinterface

// File: rtl/sobel_window_scheduler.sv
// sobel_window_scheduler: raster-scans interior 3x3 windows of a frame, fetching one
// tap per cycle from a combinational pixel memory and presenting each window by valid/ready.
module sobel_window_scheduler #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    sobel_window_scheduler_if.master bus
);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int DW = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, FETCH, OUT, FIN} state_t;
    state_t          r_state;
    logic [3:0]      r_k;
    logic [RW-1:0]   r_cr, r_row, r_win_row;
    logic [CW-1:0]   r_cc, r_col, r_win_col;
    logic [9*DW-1:0] r_win;
    logic            r_valid, r_busy, r_done;
    logic            w_wrap, w_last;
    logic [RW-1:0]   w_ncr;
    logic [CW-1:0]   w_ncc;
    assign w_wrap = r_cc == CW'(IMG_WIDTH - 2);
    assign w_last = w_wrap && r_cr == RW'(IMG_HEIGHT - 2);
    assign w_ncr  = w_wrap ? r_cr + RW'(1) : r_cr;
    assign w_ncc  = w_wrap ? CW'(1) : r_cc + CW'(1);
    // Address registers always hold the address of the tap being fetched this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_cr      <= RW'(1);
            r_cc      <= CW'(1);
            r_row     <= '0;
            r_col     <= '0;
            r_win_row <= '0;
            r_win_col <= '0;
            r_win     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= FETCH;
                    r_k     <= '0;
                    r_cr    <= RW'(1);
                    r_cc    <= CW'(1);
                    r_row   <= '0;
                    r_col   <= '0;
                    r_busy  <= 1'b1;
                end
                FETCH: begin
                    r_win[r_k*DW +: DW] <= bus.pixel;
                    if (r_k == 4'd8) begin
                        r_state   <= OUT;
                        r_k       <= '0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_valid   <= 1'b1;
                        r_win_row <= r_cr;
                        r_win_col <= r_cc;
                    end else begin
                        r_k   <= r_k + 4'd1;
                        r_row <= (r_k == 4'd2 || r_k == 4'd5) ? r_row + RW'(1) : r_row;
                        r_col <= (r_k == 4'd2 || r_k == 4'd5) ? r_col - CW'(2) : r_col + CW'(1);
                    end
                end
                OUT: if (bus.win_ready) begin
                    r_valid <= 1'b0;
                    if (w_last) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= FETCH;
                        r_cr    <= w_ncr;
                        r_cc    <= w_ncc;
                        r_row   <= w_ncr - RW'(1);
                        r_col   <= w_ncc - CW'(1);
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.row       = r_row;
    assign bus.col       = r_col;
    assign bus.win_valid = r_valid;
    assign bus.win_data  = r_win;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_sobel_window_scheduler.sv
// tb_sobel_window_scheduler: directed checks of the window scheduler against an
// (i*j)%256 pixel memory and hand-computed window taps.
module tb_sobel_window_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_vec = 0;
    int n_bad = 0;
    localparam logic [71:0] WIN_11 = {8'd4, 8'd2, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    localparam logic [71:0] WIN_66 = {8'd49, 8'd42, 8'd35, 8'd42, 8'd36, 8'd30, 8'd35, 8'd30, 8'd25};
    sobel_window_scheduler_if #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) bus ();
    sobel_window_scheduler #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    assign bus.pixel = 8'((int'(bus.row) * int'(bus.col)) % 256);
    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = 8'(((r - 1 + i) * (c - 1 + j)) % 256);
        return w;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.win_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_vec++;
        if ({bus.busy, bus.win_valid, bus.done, bus.row, bus.col, bus.win_row, bus.win_col, bus.win_data} !== 87'd0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b valid=%b done=%b row=%0d col=%0d wr=%0d wc=%0d data=%h, want all zero",
                     bus.busy, bus.win_valid, bus.done, bus.row, bus.col, bus.win_row, bus.win_col, bus.win_data);
        end
    endtask
    task automatic test_first_window();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            n_vec++;
            if ({bus.win_valid, bus.busy, bus.row, bus.col} !== {1'b0, 1'b1, 3'(k / 3), 3'(k % 3)}) begin
                n_bad++;
                $display("FAIL fetch_addr k=%0d: got valid=%b busy=%b row=%0d col=%0d, want valid=0 busy=1 row=%0d col=%0d",
                         k, bus.win_valid, bus.busy, bus.row, bus.col, k / 3, k % 3);
            end
            tick();
        end
        n_vec++;
        if ({bus.win_valid, bus.win_row, bus.win_col, bus.win_data} !== {1'b1, 3'd1, 3'd1, WIN_11}) begin
            n_bad++;
            $display("FAIL first_window: got valid=%b wr=%0d wc=%0d data=%h, want valid=1 wr=1 wc=1 data=%h",
                     bus.win_valid, bus.win_row, bus.win_col, bus.win_data, WIN_11);
        end
    endtask
    task automatic test_stall();
        bus.win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({bus.win_valid, bus.busy, bus.row, bus.col, bus.win_row, bus.win_col, bus.win_data} !==
                {1'b1, 1'b1, 3'd0, 3'd0, 3'd1, 3'd1, WIN_11}) begin
                n_bad++;
                $display("FAIL stall cyc=%0d: got valid=%b busy=%b row=%0d col=%0d wr=%0d wc=%0d data=%h, want 1 1 0 0 1 1 %h",
                         i, bus.win_valid, bus.busy, bus.row, bus.col, bus.win_row, bus.win_col, bus.win_data, WIN_11);
            end
        end
    endtask
    // Entered with the first window of a frame presented; optionally pokes start throughout.
    task automatic test_full_frame(input bit poke);
        int er = 1, ec = 1, cnt = 0, gap = 0, dones = 0;
        bus.win_ready = 1'b1;
        for (int cyc = 0; cyc < 1000 && cnt < 36; cyc++) begin
            if (bus.done) dones++;
            if (bus.win_valid) begin
                n_vec++;
                if ({bus.win_row, bus.win_col, bus.win_data} !== {3'(er), 3'(ec), exp_win(er, ec)}) begin
                    n_bad++;
                    $display("FAIL window #%0d: got wr=%0d wc=%0d data=%h, want wr=%0d wc=%0d data=%h",
                             cnt, bus.win_row, bus.win_col, bus.win_data, er, ec, exp_win(er, ec));
                end
                if (cnt > 0) begin
                    n_vec++;
                    if (gap != 10) begin
                        n_bad++;
                        $display("FAIL window_gap #%0d: got %0d cycles, want 10", cnt, gap);
                    end
                end
                if (cnt == 35) begin
                    n_vec++;
                    if (bus.win_data !== WIN_66) begin
                        n_bad++;
                        $display("FAIL last_window: got data=%h, want %h", bus.win_data, WIN_66);
                    end
                end
                cnt++;
                gap = 0;
                if (ec == 6) begin
                    ec = 1;
                    er++;
                end else ec++;
            end
            bus.start = poke && (cnt == 36 || cyc % 3 == 0);
            gap++;
            tick();
        end
        n_vec++;
        if (cnt != 36 || dones != 0) begin
            n_bad++;
            $display("FAIL window_count: got %0d windows and %0d early done pulses, want 36 and 0", cnt, dones);
        end
        n_vec++;
        if ({bus.done, bus.busy, bus.win_valid, bus.win_data} !== {1'b1, 1'b1, 1'b0, WIN_66}) begin
            n_bad++;
            $display("FAIL fin_cycle: got done=%b busy=%b valid=%b data=%h, want 1 1 0 %h",
                     bus.done, bus.busy, bus.win_valid, bus.win_data, WIN_66);
        end
        tick();
        n_vec++;
        if ({bus.done, bus.busy, bus.row, bus.col} !== 8'd0) begin
            n_bad++;
            $display("FAIL idle_after_fin: got done=%b busy=%b row=%0d col=%0d, want all 0",
                     bus.done, bus.busy, bus.row, bus.col);
        end
        tick();
        n_vec++;
        if (bus.busy !== poke) begin
            n_bad++;
            $display("FAIL start_held_after_fin: got busy=%b, want %b", bus.busy, poke);
        end
        bus.start = 1'b0;
    endtask
    task automatic test_start_ignored();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        test_full_frame(1'b1);
    endtask
    task automatic test_reset_mid_fetch();
        bit found = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.win_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            found = bus.win_valid && bus.win_row == 3'd2 && bus.win_col == 3'd2;
            tick();
        end
        repeat (4) tick();
        n_vec++;
        if (!found || {bus.busy, bus.win_valid, bus.row, bus.col} !== {1'b1, 1'b0, 3'd2, 3'd3}) begin
            n_bad++;
            $display("FAIL fetch_k4_of_2_3: found=%b busy=%b valid=%b row=%0d col=%0d, want found=1 busy=1 valid=0 row=2 col=3",
                     found, bus.busy, bus.win_valid, bus.row, bus.col);
        end
        rst = 1'b1;
        bus.start = 1'b1;
        tick();
        rst = 1'b0;
        bus.start = 1'b0;
        n_vec++;
        if ({bus.busy, bus.win_valid, bus.done, bus.row, bus.col, bus.win_row, bus.win_col, bus.win_data} !== 87'd0) begin
            n_bad++;
            $display("FAIL reset_mid_fetch: got busy=%b valid=%b done=%b row=%0d col=%0d wr=%0d wc=%0d data=%h, want all zero",
                     bus.busy, bus.win_valid, bus.done, bus.row, bus.col, bus.win_row, bus.win_col, bus.win_data);
        end
        repeat (3) tick();
        n_vec++;
        if ({bus.busy, bus.win_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL no_resume: got busy=%b valid=%b, want 0 0", bus.busy, bus.win_valid);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        n_vec++;
        if ({bus.win_valid, bus.win_row, bus.win_col, bus.win_data} !== {1'b1, 3'd1, 3'd1, WIN_11}) begin
            n_bad++;
            $display("FAIL restart_window: got valid=%b wr=%0d wc=%0d data=%h, want valid=1 wr=1 wc=1 data=%h",
                     bus.win_valid, bus.win_row, bus.win_col, bus.win_data, WIN_11);
        end
    endtask
    initial begin
        test_reset();
        test_first_window();
        test_stall();
        test_full_frame(1'b0);
        test_start_ignored();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
